// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared widths and loader state encoding.
// Also used by the fetch side so that both agree on byte order.
package imem_loader_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_WIDTH = 32;
  localparam int BYTE_WIDTH = 8;
  localparam int BIDX_WIDTH = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } loader_state_t;
endpackage

// File: rtl/imem_loader_word_byte_serializer.sv
// Word-to-byte serializer: holds one word and presents its bytes,
// most significant first, one per advance.
module imem_loader_word_byte_serializer
  import imem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [WORD_WIDTH-1:0] word,
  output logic [BYTE_WIDTH-1:0] byte_out,
  output logic                  last_byte
);
  logic [WORD_WIDTH-1:0] shift;
  logic [BIDX_WIDTH-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
      idx   <= '0;
    end else if (load) begin
      shift <= word;
      idx   <= '0;
    end else if (advance) begin
      shift <= shift << BYTE_WIDTH;
      idx   <= idx + 1'b1;
    end
  end

  assign byte_out  = shift[WORD_WIDTH-1 -: BYTE_WIDTH];
  assign last_byte = (idx == BIDX_WIDTH'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit words into the byte-wide instruction
// memory write port, big-endian, starting at BASE_ADDR.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  input  logic                  word_last,
  output logic                  word_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BYTE_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH-2:0] words_written
);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  loader_state_t         state, state_n;
  logic [ADDR_WIDTH-1:0] ptr, ptr_n;
  logic [ADDR_WIDTH-2:0] cnt, cnt_n;
  logic                  last_q, last_n;
  logic                  done_q, done_n;
  logic                  ovf_q, ovf_n;
  logic                  accept;
  logic                  in_write;
  logic                  last_byte;
  logic [BYTE_WIDTH-1:0] byte_out;

  assign accept   = (state == ACCEPT) && word_valid;
  assign in_write = (state == WRITE);

  imem_loader_word_byte_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .advance   (in_write),
    .word      (word_data),
    .byte_out  (byte_out),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= BASE;
      cnt    <= '0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
      last_q <= last_n;
      done_q <= done_n;
      ovf_q  <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    last_n  = last_q;
    done_n  = done_q;
    ovf_n   = ovf_q;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = ACCEPT;
          ptr_n   = BASE;
          cnt_n   = '0;
          done_n  = 1'b0;
          ovf_n   = 1'b0;
        end
      end
      ACCEPT: begin
        if (word_valid) begin
          last_n  = word_last;
          state_n = WRITE;
        end
      end
      WRITE: begin
        ptr_n = ptr + 1'b1;
        if (last_byte) begin
          cnt_n = cnt + 1'b1;
          // a wrapped pointer means the memory is full
          if (last_q) begin
            done_n  = 1'b1;
            state_n = DONE;
          end else if (ptr_n == '0) begin
            ovf_n   = 1'b1;
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            state_n = ACCEPT;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign word_ready    = (state == ACCEPT);
  assign busy          = (state == ACCEPT) || in_write;
  assign mem_we        = in_write;
  assign mem_addr      = in_write ? ptr : '0;
  assign mem_wdata     = in_write ? byte_out : '0;
  assign done          = done_q;
  assign overflow      = ovf_q;
  assign words_written = cnt;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random-stimulus bench for imem_loader,
// two instances with BASE_ADDR 0 and 16.
module tb_imem_loader;
  logic        clk;
  logic        rst_n;
  logic        st [2];
  logic [31:0] wd [2];
  logic        wv [2];
  logic        wl [2];
  logic        wr [2];
  logic        we [2];
  logic [7:0]  ma [2];
  logic [7:0]  md [2];
  logic        bsy [2];
  logic        dn [2];
  logic        ovf [2];
  logic [6:0]  ww [2];

  int n_cmp = 0;
  int n_err = 0;

  int m_ptr [2];
  int m_cnt [2];
  bit m_done [2];
  bit m_ovf [2];
  bit m_acc [2];
  int base [2] = '{0, 16};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(g * 16)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (st[g]),
      .word_data     (wd[g]),
      .word_valid    (wv[g]),
      .word_last     (wl[g]),
      .word_ready    (wr[g]),
      .mem_we        (we[g]),
      .mem_addr      (ma[g]),
      .mem_wdata     (md[g]),
      .busy          (bsy[g]),
      .done          (dn[g]),
      .overflow      (ovf[g]),
      .words_written (ww[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = base[d];
      m_cnt[d] = 0;
      m_done[d] = 0;
      m_ovf[d] = 0;
      m_acc[d] = 0;
    end
  endtask

  task automatic check_all_zero(input int d);
    check("rst_we", we[d], 0);
    check("rst_addr", ma[d], 0);
    check("rst_wdata", md[d], 0);
    check("rst_ready", wr[d], 0);
    check("rst_busy", bsy[d], 0);
    check("rst_done", dn[d], 0);
    check("rst_ovf", ovf[d], 0);
    check("rst_count", ww[d], 0);
  endtask

  task automatic check_status(input int d);
    check("busy", bsy[d], m_acc[d]);
    check("done", dn[d], m_done[d]);
    check("overflow", ovf[d], m_ovf[d]);
    check("count", ww[d], m_cnt[d]);
  endtask

  // Called and returns at a negedge.
  task automatic do_start(input int d);
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
    if (!m_acc[d]) begin
      m_ptr[d] = base[d];
      m_cnt[d] = 0;
      m_done[d] = 0;
      m_ovf[d] = 0;
      m_acc[d] = 1;
    end
  endtask

  // Offers one word with random valid gaps; on acceptance checks the
  // four byte writes and the post-word status. start_at pulses start
  // during the given write byte (-1: never).
  task automatic send_word(input int d, input logic [31:0] w,
                           input bit l, input int start_at,
                           output bit acc);
    acc = 0;
    for (int t = 0; t < 16 && !acc; t++) begin
      wd[d] = w;
      wl[d] = l;
      wv[d] = ($urandom_range(0, 2) != 0);
      check("ready", wr[d], m_acc[d]);
      check("idle_we", we[d], 0);
      acc = wv[d] && wr[d];
      @(negedge clk);
    end
    if (!acc && m_acc[d]) check("accept_timeout", 0, 1);
    if (!acc) begin
      wv[d] = 1'b0;
      return;
    end
    for (int k = 0; k < 4; k++) begin
      wv[d] = $urandom_range(0, 1);
      wl[d] = $urandom_range(0, 1);
      wd[d] = $urandom;
      st[d] = (k == start_at);
      check("we", we[d], 1);
      check("addr", ma[d], m_ptr[d]);
      check("wdata", md[d], (w >> (24 - 8 * k)) & 32'hFF);
      check("ready_wr", wr[d], 0);
      m_ptr[d] = (m_ptr[d] + 1) % 256;
      @(negedge clk);
    end
    st[d] = 1'b0;
    wv[d] = 1'b0;
    m_cnt[d]++;
    if (l) begin
      m_done[d] = 1;
    end else if (m_ptr[d] == 0) begin
      m_ovf[d] = 1;
      m_done[d] = 1;
    end
    m_acc[d] = !m_done[d];
    check_status(d);
  endtask

  task automatic send_n(input int d, input int n, input bit mark_last);
    bit acc;
    for (int i = 0; i < n; i++) begin
      send_word(d, $urandom, mark_last && (i == n - 1), -1, acc);
    end
  endtask

  initial begin
    bit acc;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      st[d] = 0; wd[d] = 0; wv[d] = 0; wl[d] = 0;
    end
    model_reset();
    #3;
    check_all_zero(0);
    check_all_zero(1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // valid without start is never accepted
    send_word(0, 32'h1234_5678, 1, -1, acc);
    check("no_start_accept", acc, 0);

    // two-word load
    do_start(0);
    send_word(0, 32'h2008_0005, 0, -1, acc);
    send_word(0, 32'h0000_0000, 1, -1, acc);
    check("two_done", dn[0], 1);
    check("two_count", ww[0], 2);

    // restart from DONE with start pulses during WRITE
    do_start(0);
    check_status(0);
    send_word(0, $urandom, 0, 1, acc);
    send_word(0, $urandom, 0, 3, acc);
    send_word(0, $urandom, 1, 0, acc);

    // exact fill: 64 words, last on the 64th
    do_start(0);
    send_n(0, 64, 1);
    check("fill_done", dn[0], 1);
    check("fill_ovf", ovf[0], 0);
    check("fill_count", ww[0], 64);

    // overflow: no last, 65th word refused
    do_start(0);
    send_n(0, 64, 0);
    check("ovf_flag", ovf[0], 1);
    send_word(0, 32'hDEAD_BEEF, 0, -1, acc);
    check("ovf_no_accept", acc, 0);
    check_status(0);

    // BASE_ADDR 16 instance: session, restart from DONE
    do_start(1);
    send_word(1, $urandom, 0, 2, acc);
    send_word(1, $urandom, 1, -1, acc);
    check("b16_count", ww[1], 2);
    do_start(1);
    check_status(1);
    send_word(1, 32'hCAFE_F00D, 1, -1, acc);

    // reset in the middle of a word
    do_start(0);
    wd[0] = 32'hAABB_CCDD;
    wl[0] = 0;
    wv[0] = 1;
    check("mid_ready", wr[0], 1);
    @(negedge clk);
    wv[0] = 0;
    check("mid_b0", md[0], 8'hAA);
    check("mid_a0", ma[0], 0);
    @(negedge clk);
    check("mid_b1", md[0], 8'hBB);
    check("mid_a1", ma[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero(0);
    check_all_zero(1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send_word(0, 32'h0BAD_0BAD, 0, -1, acc);
    check("post_rst_no_accept", acc, 0);
    check_status(0);

    // fresh session after reset starts again at BASE_ADDR
    do_start(0);
    send_word(0, $urandom, 1, -1, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
